// File: rtl/immed_enc.sv
// Immediate encoder: scatters a 32-bit immediate into the RISC-V I/S/B/U/J
// fields of a base instruction word, flags range/alignment/type errors, and
// buffers {err, inst} in a 2-entry FIFO behind valid/ready handshakes.
module immed_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] base,
  input  logic [2:0]  immed_type,
  input  logic [31:0] immed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [1:0]  out_err,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  // Immediate type codes shared with the immediate generator.
  localparam logic [2:0] ImmedI = 3'd0;
  localparam logic [2:0] ImmedS = 3'd1;
  localparam logic [2:0] ImmedB = 3'd2;
  localparam logic [2:0] ImmedU = 3'd3;
  localparam logic [2:0] ImmedJ = 3'd4;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrRange = 2'd1;
  localparam logic [1:0] ErrAlign = 2'd2;
  localparam logic [1:0] ErrType  = 2'd3;

  localparam logic [7:0] ErrCountMax = 8'hFF;

  logic [31:0] enc_inst;
  logic [1:0]  enc_err;
  logic        type_ok;
  logic        range_ok;
  logic        aligned;

  logic        push;
  logic        pop;

  logic [33:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [33:0] head;

  // Scatter immediate bits into the type's fields; everything else from base.
  always_comb begin
    enc_inst = base;
    case (immed_type)
      ImmedI: begin
        enc_inst[31:20] = immed[11:0];
      end
      ImmedS: begin
        enc_inst[31:25] = immed[11:5];
        enc_inst[11:7]  = immed[4:0];
      end
      ImmedB: begin
        enc_inst[31]    = immed[12];
        enc_inst[7]     = immed[11];
        enc_inst[30:25] = immed[10:5];
        enc_inst[11:8]  = immed[4:1];
      end
      ImmedU: begin
        enc_inst[31:12] = immed[31:12];
      end
      ImmedJ: begin
        enc_inst[31]    = immed[20];
        enc_inst[19:12] = immed[19:12];
        enc_inst[20]    = immed[11];
        enc_inst[30:21] = immed[10:1];
      end
      default: begin
        enc_inst = base;
      end
    endcase
  end

  // Range, alignment and type checks; sign-extension holds when the dropped
  // upper bits all equal the top encoded bit.
  always_comb begin
    type_ok  = 1'b1;
    range_ok = 1'b1;
    aligned  = 1'b1;
    case (immed_type)
      ImmedI, ImmedS: begin
        range_ok = (&immed[31:11]) | ~(|immed[31:11]);
      end
      ImmedB: begin
        range_ok = (&immed[31:12]) | ~(|immed[31:12]);
        aligned  = ~immed[0];
      end
      ImmedU: begin
        range_ok = ~(|immed[11:0]);
      end
      ImmedJ: begin
        range_ok = (&immed[31:20]) | ~(|immed[31:20]);
        aligned  = ~immed[0];
      end
      default: begin
        type_ok = 1'b0;
      end
    endcase
  end

  // Error priority: invalid type, then misaligned, then range.
  always_comb begin
    enc_err = ErrNone;
    if (!type_ok) begin
      enc_err = ErrType;
    end else if (!aligned) begin
      enc_err = ErrAlign;
    end else if (!range_ok) begin
      enc_err = ErrRange;
    end
  end

  // Handshakes; in_ready depends only on registered occupancy.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Saturating error counter; a clear wins but still counts a same-cycle error.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = (push && (enc_err != ErrNone)) ? 8'd1 : 8'd0;
    end else if (push && (enc_err != ErrNone) && (err_count_q != ErrCountMax)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      err_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  // Entry storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {enc_err, enc_inst};
    end
  end

  // Head of FIFO, forced to zero when nothing is buffered.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_inst  = out_valid ? head[31:0] : 32'd0;
    out_err   = out_valid ? head[33:32] : 2'd0;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_immed_enc.sv
// Self-checking bench for immed_enc: directed test-plan vectors plus random
// traffic against a queue-based reference model.
module tb_immed_enc;

  localparam logic [2:0] TI = 3'd0;
  localparam logic [2:0] TS = 3'd1;
  localparam logic [2:0] TB = 3'd2;
  localparam logic [2:0] TU = 3'd3;
  localparam logic [2:0] TJ = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] base = '0;
  logic [2:0]  immed_type = '0;
  logic [31:0] immed = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [7:0]  err_count;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [33:0] mq[$];
  int          mcnt = 0;

  immed_enc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .base       (base),
    .immed_type (immed_type),
    .immed      (immed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_err    (out_err),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: masks/shifts from the field table, range via signed bounds.
  function automatic logic [33:0] ref_enc(input logic [31:0] b, input logic [2:0] t,
                                          input logic [31:0] im);
    logic [31:0] mask, fields;
    int          v;
    logic        in_range, misal;
    logic [1:0]  e;
    v = $signed(im);
    mask = 32'd0;
    fields = 32'd0;
    in_range = 1'b1;
    misal = 1'b0;
    if (t == TI) begin
      mask = 32'hFFF00000;
      fields = 32'(im[11:0]) << 20;
      in_range = (v >= -2048) && (v <= 2047);
    end else if (t == TS) begin
      mask = 32'hFE000F80;
      fields = (32'(im[11:5]) << 25) | (32'(im[4:0]) << 7);
      in_range = (v >= -2048) && (v <= 2047);
    end else if (t == TB) begin
      mask = 32'hFE000F80;
      fields = (32'(im[12]) << 31) | (32'(im[11]) << 7) | (32'(im[10:5]) << 25) |
               (32'(im[4:1]) << 8);
      in_range = (v >= -4096) && (v <= 4095);
      misal = im[0];
    end else if (t == TU) begin
      mask = 32'hFFFFF000;
      fields = im & 32'hFFFFF000;
      in_range = (im % 4096) == 0;
    end else if (t == TJ) begin
      mask = 32'hFFFFF000;
      fields = (32'(im[20]) << 31) | (32'(im[10:1]) << 21) | (32'(im[11]) << 20) |
               (32'(im[19:12]) << 12);
      in_range = (v >= -(1 << 20)) && (v <= (1 << 20) - 1);
      misal = im[0];
    end
    if (t > TJ) e = 2'd3;
    else if (misal) e = 2'd2;
    else if (!in_range) e = 2'd1;
    else e = 2'd0;
    if (t > TJ) return {e, b};
    return {e, (b & ~mask) | fields};
  endfunction

  // Compare outputs with the model, then advance both across one rising edge.
  task automatic tick();
    logic        mpush, mpop;
    logic [33:0] r;
    check("in_ready", 32'(in_ready), 32'(mq.size() != 2));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("err_count", 32'(err_count), 32'(mcnt));
    if (mq.size() != 0) begin
      check("out_inst", out_inst, mq[0][31:0]);
      check("out_err", 32'(out_err), 32'(mq[0][33:32]));
    end else begin
      check("empty_inst", out_inst, 32'd0);
      check("empty_err", 32'(out_err), 32'd0);
    end
    r = ref_enc(base, immed_type, immed);
    mpush = in_valid && (mq.size() != 2);
    mpop = (mq.size() != 0) && out_ready;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back(r);
    if (err_clr) mcnt = (mpush && r[33:32] != 0) ? 1 : 0;
    else if (mpush && r[33:32] != 0 && mcnt < 255) mcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] b, input logic [2:0] t, input logic [31:0] im);
    in_valid = 1'b1;
    base = b;
    immed_type = t;
    immed = im;
  endtask

  // Accept one request, then compare the head with the plan's literal result.
  task automatic send_chk(input string tag, input logic [31:0] b, input logic [2:0] t,
                          input logic [31:0] im, input logic [31:0] exp_inst,
                          input logic [1:0] exp_err);
    drive(b, t, im);
    tick();
    in_valid = 1'b0;
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    tick();
  endtask

  function automatic logic [31:0] rand_imm();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return $urandom();
    if (sel == 1) return 32'($signed(12'($urandom())));
    if (sel == 2) return 32'($signed(21'($urandom())));
    return $urandom() & 32'hFFFFF000;
  endfunction

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick();

    // Directed vectors
    send_chk("I", 32'h00000013, TI, 32'hFFFFFFFF, 32'hFFF00013, 2'd0);
    send_chk("B", 32'h00000063, TB, 32'hFFFFF000, 32'h80000063, 2'd0);
    send_chk("U", 32'h00000037, TU, 32'h12345000, 32'h12345037, 2'd0);
    send_chk("J_mis", 32'h0000006F, TJ, 32'h00000003, 32'h0020006F, 2'd2);
    send_chk("S_rng", 32'h00000023, TS, 32'h00000800, 32'h80000023, 2'd1);
    send_chk("bad_type", 32'hDEADBEEF, 3'b111, 32'h00000000, 32'hDEADBEEF, 2'd3);
    check("err_count_3", 32'(err_count), 32'd3);

    // Backpressure: three back-to-back requests with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom(), 3'($urandom_range(0, 4)), rand_imm());
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) in_valid = 1'b0;
      tick();
    end
    // Streaming: one word per cycle
    for (int i = 0; i < 20; i++) begin
      drive($urandom(), 3'($urandom_range(0, 4)), rand_imm());
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      base = $urandom();
      immed_type = 3'($urandom_range(0, 7));
      immed = rand_imm();
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid = 1'b0;
    err_clr = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Saturation
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive($urandom(), 3'b101, $urandom());
      tick();
    end
    in_valid = 1'b0;
    check("err_sat", 32'(err_count), 32'd255);
    err_clr = 1'b1;
    drive(32'h0, 3'b110, 32'h0);
    tick();
    err_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_inc", 32'(err_count), 32'd1);
    tick();

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom(), TJ, 32'h00000001);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_inst", out_inst, 32'd0);
    mq.delete();
    mcnt = 0;
    #1;
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_chk("post_rst", 32'h00000013, TI, 32'h000007FF, 32'h7FF00013, 2'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
